matrix_reader: RTL and testbench

Read-side initiator for the matrix `memory` block. It walks a ROW×COLUMN matrix stored at a base address, drives the memory's `read`/`read_address` port, and captures the combinational read data into a registered valid/ready stream. It feeds the multiplier datapath. Column-major order delivers the B operand by columns with no separate transpose pass.

---
 rtl/matmul_pkg.sv | 18 +
 rtl/index_counter.sv | 63 ++++++
 rtl/matrix_reader.sv | 129 ++++++++++++
 tb/tb_matrix_reader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix multiplier blocks.
//   ADDR_W                        : memory address width (64-entry memory)
//   DEFAULT_ROW/COLUMN/SIZE       : default matrix geometry and element width
//   reader_state_t                : matrix_reader scan FSM states
package matmul_pkg;

    localparam int ADDR_W         = 6;
    localparam int DEFAULT_ROW    = 2;
    localparam int DEFAULT_COLUMN = 2;
    localparam int DEFAULT_SIZE   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } reader_state_t;

endpackage

// File: rtl/index_counter.sv
// 2-D row/column index counter with selectable walk order.
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : synchronously return both indices to (0,0)
//   col_major   : 0 = column index moves fastest, 1 = row index moves fastest
//   advance     : step to the next element in the selected order
//   r, c        : current row / column index
//   final_elem  : current position is the last element of the matrix
// The walk wraps back to (0,0) after the last element, so a new scan can
// start without an explicit clear.
module index_counter
    import matmul_pkg::*;
#(
    parameter int ROW    = DEFAULT_ROW,
    parameter int COLUMN = DEFAULT_COLUMN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              col_major,
    input  logic              advance,
    output logic [ADDR_W-1:0] r,
    output logic [ADDR_W-1:0] c,
    output logic              final_elem
);

    localparam logic [ADDR_W-1:0] R_MAX = ADDR_W'(ROW - 1);
    localparam logic [ADDR_W-1:0] C_MAX = ADDR_W'(COLUMN - 1);

    logic r_at_max;
    logic c_at_max;

    assign r_at_max   = (r == R_MAX);
    assign c_at_max   = (c == C_MAX);
    // Both walk orders end on the bottom-right element.
    assign final_elem = r_at_max && c_at_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
            c <= '0;
        end else if (clear) begin
            r <= '0;
            c <= '0;
        end else if (advance) begin
            if (col_major) begin
                if (r_at_max) begin
                    r <= '0;
                    c <= c_at_max ? '0 : c + 1'b1;
                end else begin
                    r <= r + 1'b1;
                end
            end else begin
                if (c_at_max) begin
                    c <= '0;
                    r <= r_at_max ? '0 : r + 1'b1;
                end else begin
                    c <= c + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/matrix_reader.sv
// Read-side initiator for the matrix memory. Walks a ROW x COLUMN matrix at a
// base address in row- or column-major order and presents each element on a
// registered valid/ready stream.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : begin a scan (only honoured in IDLE)
//   col_major         : scan order, latched on an accepted start
//   base_address      : address of element (0,0), latched on an accepted start
//   read/read_address : memory read port (data returns combinationally)
//   data              : memory read data
//   out_data/out_valid/out_ready/out_last/out_row/out_col : element stream
//   busy              : high while scanning
//   done              : one-cycle pulse after the last element is accepted
module matrix_reader
    import matmul_pkg::*;
#(
    parameter int ROW    = DEFAULT_ROW,
    parameter int COLUMN = DEFAULT_COLUMN,
    parameter int SIZE   = DEFAULT_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              col_major,
    input  logic [ADDR_W-1:0] base_address,
    output logic              read,
    output logic [ADDR_W-1:0] read_address,
    input  logic [SIZE-1:0]   data,
    output logic [SIZE-1:0]   out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [ADDR_W-1:0] out_row,
    output logic [ADDR_W-1:0] out_col,
    output logic              busy,
    output logic              done
);

    reader_state_t     state_q;
    reader_state_t     state_d;
    logic              col_major_q;
    logic [ADDR_W-1:0] base_q;
    // Set while elements of the current scan are still to be fetched; the
    // index counter wraps after the last one, so it cannot tell us this.
    logic              pending_q;

    logic              accept_start;
    logic              load;
    logic              accept_last;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] c_idx;
    logic              final_elem;
    logic [ADDR_W-1:0] addr_sum;

    assign accept_start = (state_q == IDLE) && start;
    assign load         = (state_q == STREAM) && pending_q && (!out_valid || out_ready);
    assign accept_last  = (state_q == STREAM) && out_valid && out_ready && out_last;

    // Address arithmetic deliberately wraps at ADDR_W bits.
    assign addr_sum     = base_q + ADDR_W'(r_idx * COLUMN) + c_idx;

    assign read         = load;
    assign read_address = (state_q == STREAM) ? addr_sum : '0;
    assign busy         = (state_q == STREAM);
    assign done         = (state_q == DONE);

    index_counter #(
        .ROW    (ROW),
        .COLUMN (COLUMN)
    ) u_index (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept_start),
        .col_major  (col_major_q),
        .advance    (load),
        .r          (r_idx),
        .c          (c_idx),
        .final_elem (final_elem)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = STREAM;
            STREAM:  if (accept_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            col_major_q <= 1'b0;
            base_q      <= '0;
            pending_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept_start) begin
                col_major_q <= col_major;
                base_q      <= base_address;
                pending_q   <= 1'b1;
            end else if (load && final_elem) begin
                pending_q   <= 1'b0;
            end
        end
    end

    // Output register: loads a fresh element whenever the slot is empty or
    // being drained this cycle, otherwise holds under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
        end else if (load) begin
            out_data  <= data;
            out_valid <= 1'b1;
            out_last  <= final_elem;
            out_row   <= r_idx;
            out_col   <= c_idx;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_matrix_reader.sv
module tb_matrix_reader;
    import matmul_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              col_major;
    logic [ADDR_W-1:0] base_address;
    logic              read;
    logic [ADDR_W-1:0] read_address;
    logic [7:0]        data;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [ADDR_W-1:0] out_row;
    logic [ADDR_W-1:0] out_col;
    logic              busy;
    logic              done;

    logic [7:0] mem [64];
    assign data = mem[read_address];

    always #5 clk = ~clk;

    matrix_reader #(.ROW(2), .COLUMN(2), .SIZE(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .col_major    (col_major),
        .base_address (base_address),
        .read         (read),
        .read_address (read_address),
        .data         (data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .out_row      (out_row),
        .out_col      (out_col),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        int d;
        int r;
        int c;
        int l;
    } elem_t;

    elem_t sb[$];
    int    addr_log[$];
    int    tests  = 0;
    int    fails  = 0;
    int    popped = 0;

    function automatic void check(string name, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void push(int d, int r, int c, int l);
        elem_t e;
        e.d = d; e.r = r; e.c = c; e.l = l;
        sb.push_back(e);
    endfunction

    // Monitor: an element is consumed at the next rising edge whenever
    // valid and ready are both high at the falling edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_element", 1, 0);
            end else begin
                elem_t e;
                e = sb.pop_front();
                check("out_data", int'(out_data), e.d);
                check("out_row",  int'(out_row),  e.r);
                check("out_col",  int'(out_col),  e.c);
                check("out_last", int'(out_last), e.l);
                popped++;
            end
        end
    end

    task automatic scan(input int base, input bit cm, input int stall,
                        input bit restart_mid, input int first_data);
        int  dones = 0;
        int  held  = 0;
        int  pop0;
        bit  next_ready;
        pop0       = popped;
        next_ready = (stall == 0);
        addr_log.delete();
        @(posedge clk); #1;
        out_ready    = next_ready;
        start        = 1'b1;
        col_major    = cm;
        base_address = ADDR_W'(base);
        @(posedge clk); #1;
        start        = 1'b0;
        col_major    = ~cm;              // latched copy must not follow
        base_address = ADDR_W'(base + 5);
        @(negedge clk);
        check("first_read", int'(read), 1);
        check("first_valid_low", int'(out_valid), 0);
        check("busy_stream", int'(busy), 1);
        if (read) addr_log.push_back(int'(read_address));
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            out_ready = next_ready;
            if (restart_mid && i == 1) start = 1'b1;
            if (restart_mid && i == 2) start = 1'b0;
            @(negedge clk);
            if (i == 0) check("first_valid", int'(out_valid), 1);
            if (read) addr_log.push_back(int'(read_address));
            if (done) dones++;
            if (stall > 0 && out_valid && held < stall) begin
                check("stall_hold_data", int'(out_data), first_data);
                check("stall_read_low", int'(read), 0);
                held++;
                if (held == stall) next_ready = 1'b1;
            end
        end
        check("done_pulses", dones, 1);
        check("idle_busy", int'(busy), 0);
        check("idle_read_address", int'(read_address), 0);
        check("elements_delivered", popped - pop0, 4);
        check("scoreboard_empty", sb.size(), 0);
    endtask

    initial begin
        int pop0;
        int dn;
        for (int i = 0; i < 64; i++) mem[i] = 8'd0;
        mem[0] = 8'd5; mem[1] = 8'd3; mem[2] = 8'd6; mem[3] = 8'd4;
        mem[63] = 8'd7;
        rst = 1'b1; start = 1'b0; col_major = 1'b0; base_address = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_read", int'(read), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_last", int'(out_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_read_address", int'(read_address), 0);
        @(posedge clk); #1 rst = 1'b0;

        // Row-major, base 0
        push(5,0,0,0); push(3,0,1,0); push(6,1,0,0); push(4,1,1,1);
        scan(0, 1'b0, 0, 1'b0, 5);
        check("rm_addr_count", addr_log.size(), 4);

        // Column-major, base 0
        push(5,0,0,0); push(6,1,0,0); push(3,0,1,0); push(4,1,1,1);
        scan(0, 1'b1, 0, 1'b0, 5);

        // Backpressure for 3 cycles after the first element
        push(5,0,0,0); push(3,0,1,0); push(6,1,0,0); push(4,1,1,1);
        scan(0, 1'b0, 3, 1'b0, 5);

        // Address wrap from 63
        push(7,0,0,0); push(5,0,1,0); push(3,1,0,0); push(6,1,1,1);
        scan(63, 1'b0, 0, 1'b0, 7);
        check("wrap_addr_count", addr_log.size(), 4);
        if (addr_log.size() == 4) begin
            check("wrap_addr0", addr_log[0], 63);
            check("wrap_addr1", addr_log[1], 0);
            check("wrap_addr2", addr_log[2], 1);
            check("wrap_addr3", addr_log[3], 2);
        end

        // start pulsed mid-scan is ignored
        push(5,0,0,0); push(3,0,1,0); push(6,1,0,0); push(4,1,1,1);
        scan(0, 1'b0, 0, 1'b1, 5);

        // Reset after the second element
        push(5,0,0,0); push(3,0,1,0); push(6,1,0,0); push(4,1,1,1);
        pop0 = popped;
        @(posedge clk); #1;
        out_ready = 1'b1; start = 1'b1; col_major = 1'b0; base_address = '0;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (popped - pop0 >= 2) break;
        end
        check("pre_reset_pops", popped - pop0, 2);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_data", int'(out_data), 0);
        check("async_rst_row", int'(out_row), 0);
        check("async_rst_col", int'(out_col), 0);
        check("async_rst_read", int'(read), 0);
        check("async_rst_addr", int'(read_address), 0);
        check("async_rst_busy", int'(busy), 0);
        sb.delete();
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dn++;
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("no_done_after_abort", dn, 0);

        // Restart after abort begins at (0,0)
        push(5,0,0,0); push(3,0,1,0); push(6,1,0,0); push(4,1,1,1);
        scan(0, 1'b0, 0, 1'b0, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
